alu_seq: RTL

Parametrised multi-cycle successor to the combinational calculator ALU in the Passcoder datapath. It accepts BCD operands from the keypad decoder and runs a start/done handshake. Mul, div and pow are iterative. The binary result is converted to BCD digits for the 7-segment driver, and the block reports sign, a decimal-point position and an error condition.

---
 rtl/alu_seq.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-cycle BCD calculator ALU: add/sub/mul/div/pow with start/done handshake
// and double-dabble result conversion. Define ALU_SEQ_MOD_EN to enable op 101 (modulo).
module alu_seq #(
  parameter int unsigned IN_DIGITS  = 2,
  parameter int unsigned OUT_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*IN_DIGITS-1:0]  a_bcd,
  input  logic [4*IN_DIGITS-1:0]  b_bcd,
  input  logic [2:0]              op,
  output logic                    busy,
  output logic                    done,
  output logic [4*OUT_DIGITS-1:0] result_bcd,
  output logic                    neg,
  output logic                    dp,
  output logic                    err
);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned AW   = $clog2(pow10(IN_DIGITS));
  localparam int unsigned RW   = $clog2(pow10(OUT_DIGITS));
  localparam int unsigned MAXR = pow10(OUT_DIGITS) - 1;
  localparam int unsigned XW   = (2*AW > RW+1) ? 2*AW : RW+1;
  localparam int unsigned PW   = XW + AW;
  localparam int unsigned CW   = (AW > $clog2(RW+1)) ? AW : $clog2(RW+1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_POW = 3'b100;
`ifdef ALU_SEQ_MOD_EN
  localparam logic [2:0] OP_MOD = 3'b101;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CONV, S_DONE} state_e;

  // Digits above 9 saturate to 9 before weighting.
  function automatic logic [AW-1:0] bcd2bin(input logic [4*IN_DIGITS-1:0] x);
    int unsigned v;
    logic [3:0]  d;
    v = 0;
    for (int unsigned i = IN_DIGITS; i > 0; i--) begin
      d = x[4*(i-1) +: 4];
      if (d > 4'd9) d = 4'd9;
      v = v * 10 + 32'(d);
    end
    return AW'(v);
  endfunction

  state_e                  state_q;
  logic [2:0]              op_q;
  logic [AW-1:0]           a_q, b_q, b_sh_q;
  logic [XW-1:0]           acc_q, a_sh_q;
  logic [RW-1:0]           dvd_q;
  logic [AW-1:0]           rem_q;
  logic                    ovf_q;
  logic [CW-1:0]           cnt_q;
  logic [RW-1:0]           bin_q;
  logic [4*OUT_DIGITS-1:0] bcd_q, res_q;
  logic                    busy_q, done_q, neg_q, dp_q, err_q;

  logic [AW-1:0]           a_in, b_in;
  logic [XW-1:0]           acc_d, fin_res;
  logic                    ovf_d, fin_err, fin_neg, fin_dp;
  logic [PW-1:0]           prod;
  logic [AW:0]             div_t;
  logic                    q_bit;
  logic [AW-1:0]           rem_d;
  logic [RW-1:0]           dvd_d, bin_d;
  logic [4*OUT_DIGITS-1:0] adj, bcd_d;

  assign a_in = bcd2bin(a_bcd);
  assign b_in = bcd2bin(b_bcd);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    prod  = PW'(acc_q) * PW'(a_q);
    // Restoring divider: quotient bits shift into the dividend register.
    div_t = {rem_q, dvd_q[RW-1]};
    q_bit = (div_t >= {1'b0, b_q});
    rem_d = q_bit ? AW'(div_t - {1'b0, b_q}) : div_t[AW-1:0];
    dvd_d = {dvd_q[RW-2:0], q_bit};
    case (op_q)
      OP_ADD: acc_d = XW'(a_q) + XW'(b_q);
      OP_SUB: acc_d = (a_q >= b_q) ? XW'(a_q - b_q) : XW'(b_q - a_q);
      OP_MUL: acc_d = acc_q + (b_sh_q[0] ? a_sh_q : '0);
      OP_POW: begin
        if (b_q != '0) begin
          if (prod > PW'(MAXR)) begin
            acc_d = XW'(MAXR + 1);
            ovf_d = 1'b1;
          end else begin
            acc_d = XW'(prod);
          end
        end
      end
      default: ;
    endcase

    fin_res = acc_d;
    fin_err = ovf_d;
    fin_neg = 1'b0;
    fin_dp  = 1'b0;
    case (op_q)
      OP_ADD, OP_MUL, OP_POW: ;
      OP_SUB: fin_neg = (a_q < b_q);
      OP_DIV: begin
        fin_res = XW'(dvd_d);
        fin_dp  = 1'b1;
        if (b_q == '0) fin_err = 1'b1;
      end
`ifdef ALU_SEQ_MOD_EN
      OP_MOD: begin
        fin_res = XW'(rem_d);
        if (b_q == '0) fin_err = 1'b1;
      end
`endif
      default: fin_err = 1'b1;
    endcase
    if (fin_res > XW'(MAXR)) fin_err = 1'b1;
    if (fin_err) fin_res = '0;
  end

  // Double-dabble step: add 3 to digits >= 5, then shift left one bit.
  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < OUT_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_d = {adj[4*OUT_DIGITS-2:0], bin_q[RW-1]};
    bin_d = {bin_q[RW-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      a_sh_q  <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      dp_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q   <= op;
            a_q    <= a_in;
            b_q    <= b_in;
            b_sh_q <= b_in;
            a_sh_q <= XW'(a_in);
            acc_q  <= (op == OP_POW) ? XW'(1) : '0;
            dvd_q  <= (op == OP_DIV) ? RW'(a_in * 10) : RW'(a_in);
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            neg_q  <= 1'b0;
            dp_q   <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            case (op)
              OP_MUL:  cnt_q <= CW'(AW - 1);
              OP_DIV:  cnt_q <= CW'(RW - 1);
`ifdef ALU_SEQ_MOD_EN
              OP_MOD:  cnt_q <= CW'(RW - 1);
`endif
              OP_POW:  cnt_q <= (b_in == '0) ? '0 : CW'(b_in - 1'b1);
              default: cnt_q <= '0;
            endcase
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc_q  <= acc_d;
          ovf_q  <= ovf_d;
          a_sh_q <= a_sh_q << 1;
          b_sh_q <= b_sh_q >> 1;
          dvd_q  <= dvd_d;
          rem_q  <= rem_d;
          if (cnt_q == '0) begin
            neg_q   <= fin_neg;
            dp_q    <= fin_dp;
            err_q   <= fin_err;
            bin_q   <= RW'(fin_res);
            bcd_q   <= '0;
            cnt_q   <= CW'(RW - 1);
            state_q <= S_CONV;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_CONV: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          if (cnt_q == '0) begin
            res_q   <= bcd_d;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result_bcd = res_q;
  assign neg        = neg_q;
  assign dp         = dp_q;
  assign err        = err_q;

endmodule
